// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/lsq request ports and physical memory port shared by the arbiter.
interface mem_port_arbiter_if;
    logic        instr_read;
    logic [31:0] instr_mem_address;
    logic        instr_mem_resp;
    logic [31:0] instr_mem_rdata;

    logic        data_read;
    logic        data_write;
    logic [31:0] data_mem_address;
    logic [3:0]  data_mbe;
    logic [31:0] data_mem_wdata;
    logic        data_mem_resp;
    logic [31:0] data_mem_rdata;

    logic        flush_ip;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_mbe;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    logic        grant_instr;
    logic        grant_data;

    modport slave (
        input  instr_read, instr_mem_address,
        output instr_mem_resp, instr_mem_rdata,
        input  data_read, data_write, data_mem_address, data_mbe, data_mem_wdata,
        output data_mem_resp, data_mem_rdata,
        input  flush_ip,
        output mem_read, mem_write, mem_address, mem_mbe, mem_wdata,
        input  mem_resp, mem_rdata,
        output grant_instr, grant_data
    );

    modport master (
        output instr_read, instr_mem_address,
        input  instr_mem_resp, instr_mem_rdata,
        output data_read, data_write, data_mem_address, data_mbe, data_mem_wdata,
        input  data_mem_resp, data_mem_rdata,
        output flush_ip,
        input  mem_read, mem_write, mem_address, mem_mbe, mem_wdata,
        output mem_resp, mem_rdata,
        input  grant_instr, grant_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and the lsq.
// The lsq wins by default; a starvation streak forces a fetch grant; flushed fetches drop their response.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] INSTR = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;

    logic [1:0]    state;
    logic [SW-1:0] streak;
    logic          drop;
    logic          flush_q;

    logic fetch_ok;
    logic data_req;
    logic pick_data;
    logic pick_instr;
    logic flush_rise;

    always_comb begin
        fetch_ok   = bus.instr_read & ~bus.flush_ip;
        data_req   = bus.data_read | bus.data_write;
        pick_data  = (state == IDLE) & data_req & ((streak < LIMIT) | ~fetch_ok);
        pick_instr = (state == IDLE) & ~pick_data & fetch_ok;
        flush_rise = bus.flush_ip & ~flush_q;
    end

    // A flush edge landing in the very cycle of mem_resp must also suppress the response.
    assign bus.instr_mem_resp  = (state == INSTR) & bus.mem_resp & ~drop & ~flush_rise;
    assign bus.data_mem_resp   = (state == DATA) & bus.mem_resp;
    assign bus.instr_mem_rdata = bus.mem_rdata;
    assign bus.data_mem_rdata  = bus.mem_rdata;
    assign bus.grant_instr     = (state == INSTR);
    assign bus.grant_data      = (state == DATA);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            streak          <= '0;
            drop            <= 1'b0;
            flush_q         <= 1'b0;
            bus.mem_read    <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_mbe     <= '0;
            bus.mem_wdata   <= '0;
        end else begin
            flush_q <= bus.flush_ip;
            case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (pick_data) begin
                        state           <= DATA;
                        bus.mem_address <= bus.data_mem_address;
                        bus.mem_wdata   <= bus.data_mem_wdata;
                        // A store wins over a simultaneous load.
                        bus.mem_write   <= bus.data_write;
                        bus.mem_read    <= ~bus.data_write;
                        bus.mem_mbe     <= bus.data_write ? bus.data_mbe : 4'b1111;
                        if (fetch_ok)
                            streak <= (streak == LIMIT) ? LIMIT : streak + 1'b1;
                        else
                            streak <= '0;
                    end else if (pick_instr) begin
                        state           <= INSTR;
                        bus.mem_address <= bus.instr_mem_address;
                        bus.mem_read    <= 1'b1;
                        bus.mem_write   <= 1'b0;
                        bus.mem_mbe     <= 4'b1111;
                        streak          <= '0;
                    end else if (!fetch_ok) begin
                        streak <= '0;
                    end
                end
                INSTR, DATA: begin
                    if ((state == INSTR) && flush_rise)
                        drop <= 1'b1;
                    if (bus.mem_resp) begin
                        state         <= IDLE;
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                        drop          <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;
    localparam logic [1:0] K_FETCH = 2'd0;
    localparam logic [1:0] K_LOAD  = 2'd1;
    localparam logic [1:0] K_STORE = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [3:0]  mbe;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
        logic        exp_read;
        logic        exp_write;
        logic [3:0]  exp_mbe;
    } vec_t;

    typedef struct {
        logic        is_instr;
        logic [31:0] rdata;
    } resp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    resp_t sb[$];
    vec_t  vecs[6];

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            assert (!(bus.data_read && bus.data_write))
                else $error("data_read and data_write both high");
            if (bus.instr_mem_resp || bus.data_mem_resp) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: instr=%0b data=%0b with nothing outstanding",
                             bus.instr_mem_resp, bus.data_mem_resp);
                end else begin
                    resp_t e;
                    e = sb.pop_front();
                    chk("resp_port", {31'b0, bus.instr_mem_resp}, {31'b0, e.is_instr});
                    chk("resp_rdata", bus.instr_mem_resp ? bus.instr_mem_rdata : bus.data_mem_rdata, e.rdata);
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        bus.instr_read = (v.kind == K_FETCH);
        bus.data_read  = (v.kind == K_LOAD);
        bus.data_write = (v.kind == K_STORE);
        bus.instr_mem_address = v.addr;
        bus.data_mem_address  = v.addr;
        bus.data_mbe          = v.mbe;
        bus.data_mem_wdata    = v.wdata;
        bus.mem_rdata         = 32'hDEAD_DEAD;
        sb.push_back('{v.kind == K_FETCH, v.rdata});
        next_cycle();
        // Scramble requester inputs: mem_* must keep the latched values.
        bus.instr_mem_address = ~v.addr;
        bus.data_mem_address  = ~v.addr;
        bus.data_mbe          = ~v.mbe;
        bus.data_mem_wdata    = ~v.wdata;
        for (int k = 1; k <= v.lat; k++) begin
            if (k == v.lat) begin
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = v.rdata;
            end
            @(negedge clk);
            chk("mem_read", {31'b0, bus.mem_read}, {31'b0, v.exp_read});
            chk("mem_write", {31'b0, bus.mem_write}, {31'b0, v.exp_write});
            chk("mem_address", bus.mem_address, v.addr);
            chk("mem_mbe", {28'b0, bus.mem_mbe}, {28'b0, v.exp_mbe});
            chk("grant_instr", {31'b0, bus.grant_instr}, {31'b0, v.kind == K_FETCH});
            chk("grant_data", {31'b0, bus.grant_data}, {31'b0, v.kind != K_FETCH});
            if (v.kind == K_STORE)
                chk("mem_wdata", bus.mem_wdata, v.wdata);
            if (k < v.lat)
                chk("early_resp", {31'b0, bus.instr_mem_resp | bus.data_mem_resp}, 32'd0);
            next_cycle();
        end
        bus.mem_resp   = 1'b0;
        bus.mem_rdata  = 32'hDEAD_DEAD;
        bus.instr_read = 1'b0;
        bus.data_read  = 1'b0;
        bus.data_write = 1'b0;
        @(negedge clk);
        chk("idle_cmd", {30'b0, bus.mem_read, bus.mem_write}, 32'd0);
        chk("idle_grant", {30'b0, bus.grant_instr, bus.grant_data}, 32'd0);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t nf;
        logic got;
        logic exp_data;

        vecs[0] = '{K_FETCH, 32'h0000_0060, 4'h0, 32'h0,         32'h0000_0013, 3, 1'b1, 1'b0, 4'hF};
        vecs[1] = '{K_LOAD,  32'h0000_0104, 4'h0, 32'h0,         32'hCAFE_F00D, 1, 1'b1, 1'b0, 4'hF};
        vecs[2] = '{K_STORE, 32'h0000_0108, 4'hC, 32'h1234_5678, 32'h0000_0001, 2, 1'b0, 1'b1, 4'hC};
        vecs[3] = '{K_FETCH, 32'hFFFF_FFFC, 4'h0, 32'h0,         32'hFFFF_FFFF, 1, 1'b1, 1'b0, 4'hF};
        vecs[4] = '{K_STORE, 32'h0000_0000, 4'h1, 32'h0000_00A5, 32'h0000_0002, 5, 1'b0, 1'b1, 4'h1};
        vecs[5] = '{K_STORE, 32'h0000_0FF0, 4'hF, 32'h8000_0001, 32'h0000_0003, 1, 1'b0, 1'b1, 4'hF};

        rst = 1'b0;
        bus.instr_read = 1'b0; bus.instr_mem_address = '0;
        bus.data_read = 1'b0;  bus.data_write = 1'b0;
        bus.data_mem_address = '0; bus.data_mbe = '0; bus.data_mem_wdata = '0;
        bus.flush_ip = 1'b0; bus.mem_resp = 1'b0; bus.mem_rdata = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd", {30'b0, bus.mem_read, bus.mem_write}, 32'd0);
        chk("rst_resp", {30'b0, bus.instr_mem_resp, bus.data_mem_resp}, 32'd0);
        chk("rst_grant", {30'b0, bus.grant_instr, bus.grant_data}, 32'd0);
        chk("rst_address", bus.mem_address, 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mbe", {28'b0, bus.mem_mbe}, 32'd0);
        chk("rst_streak", {29'b0, dut.streak}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i]);

        // Store and fetch arrive together: store first, fetch in the IDLE cycle after.
        bus.data_write = 1'b1; bus.data_mem_address = 32'h100; bus.data_mbe = 4'b0011;
        bus.data_mem_wdata = 32'hBEEF;
        bus.instr_read = 1'b1; bus.instr_mem_address = 32'h400;
        sb.push_back('{1'b0, 32'h0000_1111});
        sb.push_back('{1'b1, 32'h0000_2222});
        next_cycle();
        @(negedge clk);
        chk("prio_grant_data", {31'b0, bus.grant_data}, 32'd1);
        chk("prio_mem_write", {31'b0, bus.mem_write}, 32'd1);
        chk("prio_mbe", {28'b0, bus.mem_mbe}, 32'b0011);
        chk("prio_wdata", bus.mem_wdata, 32'hBEEF);
        next_cycle();
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'h1111;
        next_cycle();
        bus.mem_resp = 1'b0; bus.data_write = 1'b0;
        @(negedge clk);
        chk("prio_gap_idle", {30'b0, bus.grant_instr, bus.grant_data}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("prio_grant_instr", {31'b0, bus.grant_instr}, 32'd1);
        chk("prio_instr_addr", bus.mem_address, 32'h400);
        next_cycle();
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'h2222;
        next_cycle();
        bus.mem_resp = 1'b0; bus.instr_read = 1'b0;
        next_cycle();

        // Continuous loads with a waiting fetch: four DATA grants, then INSTR, then DATA with streak 0.
        bus.data_read = 1'b1; bus.data_mem_address = 32'h500;
        bus.instr_read = 1'b1; bus.instr_mem_address = 32'h600;
        for (int t = 0; t < 6; t++)
            sb.push_back('{t == 4, 32'h1000 + t});
        for (int t = 0; t < 6; t++) begin
            got = 1'b0;
            for (int w = 0; w < 6 && !got; w++) begin
                @(negedge clk);
                if (bus.grant_instr || bus.grant_data) got = 1'b1;
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL starve_wait: no grant for transaction %0d", t);
            end
            exp_data = (t != 4);
            chk("starve_grant_data", {31'b0, bus.grant_data}, {31'b0, exp_data});
            chk("starve_streak", {29'b0, dut.streak}, (t < 4) ? t + 1 : 0);
            bus.mem_rdata = 32'h1000 + t;
            next_cycle();
            bus.mem_resp = 1'b1;
            next_cycle();
            bus.mem_resp = 1'b0;
            if (t == 4) bus.instr_read = 1'b0;
            if (t == 5) bus.data_read = 1'b0;
        end
        next_cycle();

        // Flush pulse during a fetch: command stays up, response dropped.
        bus.instr_read = 1'b1; bus.instr_mem_address = 32'h200;
        next_cycle();
        @(negedge clk);
        chk("flush_grant", {31'b0, bus.grant_instr}, 32'd1);
        next_cycle();
        bus.flush_ip = 1'b1;
        @(negedge clk);
        chk("flush_read_c2", {31'b0, bus.mem_read}, 32'd1);
        next_cycle();
        bus.flush_ip = 1'b0;
        @(negedge clk);
        chk("flush_read_c3", {31'b0, bus.mem_read}, 32'd1);
        next_cycle();
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'h0BAD;
        @(negedge clk);
        chk("flush_read_c4", {31'b0, bus.mem_read}, 32'd1);
        chk("flush_dropped", {31'b0, bus.instr_mem_resp}, 32'd0);
        next_cycle();
        bus.mem_resp = 1'b0; bus.instr_read = 1'b0;
        @(negedge clk);
        chk("flush_idle", {31'b0, bus.mem_read}, 32'd0);
        next_cycle();
        nf = '{K_FETCH, 32'h0000_0204, 4'h0, 32'h0, 32'h0000_0055, 2, 1'b1, 1'b0, 4'hF};
        run_vec(nf);

        // Flush with fetch in IDLE blocks the fetch; a stray mem_resp in IDLE is ignored; data still granted.
        bus.instr_read = 1'b1; bus.flush_ip = 1'b1; bus.mem_resp = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("flush_idle_grant", {30'b0, bus.grant_instr, bus.grant_data}, 32'd0);
            chk("flush_idle_cmd", {31'b0, bus.mem_read}, 32'd0);
            next_cycle();
        end
        bus.mem_resp = 1'b0;
        bus.data_read = 1'b1; bus.data_mem_address = 32'h700;
        sb.push_back('{1'b0, 32'h4242});
        next_cycle();
        @(negedge clk);
        chk("flush_data_grant", {30'b0, bus.grant_instr, bus.grant_data}, 32'b01);
        next_cycle();
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'h4242;
        bus.instr_read = 1'b0; bus.flush_ip = 1'b0;
        next_cycle();
        bus.mem_resp = 1'b0; bus.data_read = 1'b0;
        next_cycle();

        // Async reset mid-DATA between edges; held store is re-granted at the first edge.
        bus.data_write = 1'b1; bus.data_mem_address = 32'h300; bus.data_mbe = 4'hF;
        bus.data_mem_wdata = 32'h77;
        sb.push_back('{1'b0, 32'h99});
        next_cycle();
        @(negedge clk);
        chk("ar_pre_grant", {31'b0, bus.grant_data}, 32'd1);
        #2 rst = 1'b0;
        #0.5;
        chk("ar_mem_write", {31'b0, bus.mem_write}, 32'd0);
        chk("ar_grant_data", {31'b0, bus.grant_data}, 32'd0);
        chk("ar_address", bus.mem_address, 32'd0);
        #0.5 rst = 1'b1;
        #1;
        chk("ar_post_idle", {30'b0, bus.grant_instr, bus.grant_data}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("ar_regrant", {31'b0, bus.grant_data}, 32'd1);
        chk("ar_regrant_write", {31'b0, bus.mem_write}, 32'd1);
        chk("ar_regrant_addr", bus.mem_address, 32'h300);
        next_cycle();
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'h99;
        next_cycle();
        bus.mem_resp = 1'b0; bus.data_write = 1'b0;
        repeat (2) next_cycle();

        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
